pwm_decoder: RTL and testbench

Receive-side counterpart of the team's 8-bit PWM generator: samples a single-bit PWM waveform, measures high time and period in clk cycles, and recovers the 8-bit duty code that drove the generator. Sits at the input of a loopback or remote-control path; the recovered duty is presented with a one-cycle valid strobe once per PWM period. Also flags stuck-high and stuck-low (0 %/100 %) lines via a timeout.

---
 rtl/pwm_decoder.sv | 127 ++++++++++++
 tb/tb_pwm_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// Recovers the 8-bit duty code and period from a sampled PWM waveform, one
// valid strobe per complete period, with stuck-high/stuck-low timeout flags.
module pwm_decoder #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic [CNT_W:0]   period_out,
  output logic             duty_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             locked
);

  localparam int MW = CNT_W + 2;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [MW-1:0] ONE  = MW'(1);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;
  logic [MW-1:0]          per_q, per_d, hi_q, hi_d;
  logic [IW-1:0]          idle_q;
  logic [CNT_W-1:0]       duty_q, duty_d;
  logic [CNT_W:0]         period_q, period_d;
  logic                   valid_q, valid_d, sh_q, sh_d, sl_q, sl_d, lock_q, lock_d;

  logic pwm_s, rise, to_stuck;
  assign pwm_s    = sync_q[SYNC_STAGES-1];
  assign rise     = pwm_s & ~pwm_d_q;
  // A rise in the same cycle as the timeout wins.
  assign to_stuck = (idle_q == TMAX) && !rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      pwm_d_q  <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q  <= pwm_s;
      per_q    <= per_d;
      hi_q     <= hi_d;
      idle_q   <= rise ? '0 : ((idle_q == TMAX) ? TMAX : idle_q + 1'b1);
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    sh_d     = sh_q;
    sl_d     = sl_q;
    lock_d   = lock_q;
    case (state_q)
      IDLE, MEAS: begin
        if (rise) begin
          if (state_q == MEAS) begin
            duty_d   = (|hi_q[MW-1:CNT_W]) ? '1 : hi_q[CNT_W-1:0];
            period_d = per_q[MW-1] ? '1 : per_q[CNT_W:0];
            valid_d  = 1'b1;
            lock_d   = 1'b1;
          end
          state_d = MEAS;
          per_d   = ONE;
          hi_d    = ONE;
        end else if (to_stuck) begin
          state_d  = STUCK;
          sh_d     = pwm_s;
          sl_d     = ~pwm_s;
          duty_d   = pwm_s ? '1 : '0;
          period_d = '0;
          lock_d   = 1'b0;
          valid_d  = 1'b1;
        end else if (state_q == MEAS) begin
          if (per_q != '1) per_d = per_q + ONE;
          if (pwm_s && hi_q != '1) hi_d = hi_q + ONE;
        end
      end
      STUCK: begin
        // Rise restarts measurement; the first window is partial, so no valid.
        if (rise) begin
          state_d = MEAS;
          sh_d    = 1'b0;
          sl_d    = 1'b0;
          per_d   = ONE;
          hi_d    = ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign duty_valid = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;
  assign locked     = lock_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: generator-style waveforms, stuck lines,
// saturation and mid-window reset, checked against hand-computed values.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] duty_out;
  logic [8:0] period_out;
  logic       duty_valid, stuck_high, stuck_low, locked;

  int checks = 0, failures = 0;
  int nvalid = 0, nsv = 0, consec = 0;
  int last_duty = 0, last_period = 0;
  logic prev_v = 1'b0;

  pwm_decoder dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty_out(duty_out), .period_out(period_out), .duty_valid(duty_valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (duty_valid) begin
      nvalid++;
      if (stuck_high || stuck_low) nsv++;
      last_duty   = int'(duty_out);
      last_period = int'(period_out);
      if (prev_v) consec++;
    end
    prev_v = duty_valid;
  endtask

  task automatic run_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      step();
    end
  endtask

  task automatic run_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      pwm_in = (i < hi);
      step();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, int'(duty_out), 0);
    chk({tag, "_period"}, int'(period_out), 0);
    chk({tag, "_valid"}, int'(duty_valid), 0);
    chk({tag, "_sh"}, int'(stuck_high), 0);
    chk({tag, "_sl"}, int'(stuck_low), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) step();
    chk_zero("reset");
    rst = 1'b0;
    run_level(0, 8);

    // Duty 10 / period 256: two valids from three rises.
    nvalid = 0;
    for (int p = 0; p < 3; p++) run_period(10, 256);
    chk("d10_nvalid", nvalid, 2);
    chk("d10_duty", last_duty, 10);
    chk("d10_period", last_period, 256);
    chk("d10_locked", int'(locked), 1);

    // Duty 255 at window boundary.
    for (int p = 0; p < 2; p++) run_period(255, 256);
    chk("d255_duty", last_duty, 255);
    chk("d255_period", last_period, 256);
    chk("d255_flags", int'(stuck_high) + int'(stuck_low), 0);

    // Stuck high: closing valid for last window plus one stuck pulse.
    nvalid = 0; nsv = 0;
    run_level(1, 600);
    chk("sh_flag", int'(stuck_high), 1);
    chk("sh_low_excl", int'(stuck_low), 0);
    chk("sh_duty", int'(duty_out), 255);
    chk("sh_period", int'(period_out), 0);
    chk("sh_locked", int'(locked), 0);
    chk("sh_pulses", nsv, 1);
    chk("sh_nvalid", nvalid, 2);

    // Restart duty 128.
    run_level(0, 4);
    nvalid = 0;
    run_period(128, 256);
    chk("rst128_sh_clear", int'(stuck_high), 0);
    chk("rst128_novalid", nvalid, 0);
    chk("rst128_unlocked", int'(locked), 0);
    for (int p = 0; p < 2; p++) run_period(128, 256);
    chk("d128_duty", last_duty, 128);
    chk("d128_period", last_period, 256);
    chk("d128_locked", int'(locked), 1);

    // Stuck low.
    nsv = 0;
    run_level(0, 600);
    chk("sl_flag", int'(stuck_low), 1);
    chk("sl_high_excl", int'(stuck_high), 0);
    chk("sl_duty", int'(duty_out), 0);
    chk("sl_period", int'(period_out), 0);
    chk("sl_pulses", nsv, 1);

    // Period 300, high 290: duty saturates.
    for (int p = 0; p < 3; p++) run_period(290, 300);
    chk("p300_duty", last_duty, 255);
    chk("p300_period", last_period, 300);
    chk("p300_sl_clear", int'(stuck_low), 0);

    // Period 700 exceeds the timeout: stuck entry (low phase) instead of valid.
    nvalid = 0; nsv = 0;
    run_period(350, 700);
    chk("p700_nvalid", nvalid, 2);
    chk("p700_stuck_pulse", nsv, 1);
    chk("p700_last_period", last_period, 0);
    chk("p700_sl", int'(stuck_low), 1);
    chk("p700_sh", int'(stuck_high), 0);

    // Duty 64, then reset at cycle 100 of a window.
    for (int p = 0; p < 2; p++) run_period(64, 256);
    chk("d64_pre_duty", last_duty, 64);
    run_period(64, 100);
    rst = 1'b1;
    pwm_in = 1'b0;
    step();
    chk_zero("midrst");
    rst = 1'b0;
    run_level(0, 155);
    nvalid = 0;
    run_period(64, 256);
    chk("postrst_novalid", nvalid, 0);
    run_period(64, 256);
    chk("postrst_nvalid", nvalid, 1);
    chk("postrst_duty", last_duty, 64);
    chk("postrst_period", last_period, 256);

    chk("no_consec_valid", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
